// File: rtl/rom_async_if.sv
// Read bus for the 64x4 constant lookup table: enable, address and read data.
interface rom_async_if;
    logic       en;
    logic [5:0] addr;
    logic [3:0] dout;

    // Master drives the lookup request and receives the word.
    modport master (
        output en,
        output addr,
        input  dout
    );

    // Slave is the table itself.
    modport slave (
        input  en,
        input  addr,
        output dout
    );
endinterface

// File: rtl/rom_async.sv
// 64-word x 4-bit constant lookup table with a zero-latency read path.
// While enabled the output follows the address combinationally; while
// disabled it shows the last word captured on a clock edge with en=1.
module rom_async (
    input  logic       clk,
    input  logic       rst_n,
    rom_async_if.slave bus
);

    logic [3:0] word;
    logic [3:0] hold_q;

    // Constant table: word[a] = a[3:0] ^ {2'b00, a[5:4]}.
    // Default is X so an unknown address propagates rather than aliasing.
    always_comb begin
        word = 4'bxxxx;
        case (bus.addr)
            6'd0:  word = 4'h0;  6'd1:  word = 4'h1;  6'd2:  word = 4'h2;  6'd3:  word = 4'h3;
            6'd4:  word = 4'h4;  6'd5:  word = 4'h5;  6'd6:  word = 4'h6;  6'd7:  word = 4'h7;
            6'd8:  word = 4'h8;  6'd9:  word = 4'h9;  6'd10: word = 4'ha;  6'd11: word = 4'hb;
            6'd12: word = 4'hc;  6'd13: word = 4'hd;  6'd14: word = 4'he;  6'd15: word = 4'hf;
            6'd16: word = 4'h1;  6'd17: word = 4'h0;  6'd18: word = 4'h3;  6'd19: word = 4'h2;
            6'd20: word = 4'h5;  6'd21: word = 4'h4;  6'd22: word = 4'h7;  6'd23: word = 4'h6;
            6'd24: word = 4'h9;  6'd25: word = 4'h8;  6'd26: word = 4'hb;  6'd27: word = 4'ha;
            6'd28: word = 4'hd;  6'd29: word = 4'hc;  6'd30: word = 4'hf;  6'd31: word = 4'he;
            6'd32: word = 4'h2;  6'd33: word = 4'h3;  6'd34: word = 4'h0;  6'd35: word = 4'h1;
            6'd36: word = 4'h6;  6'd37: word = 4'h7;  6'd38: word = 4'h4;  6'd39: word = 4'h5;
            6'd40: word = 4'ha;  6'd41: word = 4'hb;  6'd42: word = 4'h8;  6'd43: word = 4'h9;
            6'd44: word = 4'he;  6'd45: word = 4'hf;  6'd46: word = 4'hc;  6'd47: word = 4'hd;
            6'd48: word = 4'h3;  6'd49: word = 4'h2;  6'd50: word = 4'h1;  6'd51: word = 4'h0;
            6'd52: word = 4'h7;  6'd53: word = 4'h6;  6'd54: word = 4'h5;  6'd55: word = 4'h4;
            6'd56: word = 4'hb;  6'd57: word = 4'ha;  6'd58: word = 4'h9;  6'd59: word = 4'h8;
            6'd60: word = 4'hf;  6'd61: word = 4'he;  6'd62: word = 4'hd;  6'd63: word = 4'hc;
            default: word = 4'bxxxx;
        endcase
    end

    // Hold register: captures the live word on enabled edges, clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 4'b0000;
        end else if (bus.en) begin
            hold_q <= word;
        end
    end

    // Output mux: reset does not gate the live path.
    always_comb begin
        bus.dout = bus.en ? word : hold_q;
    end

endmodule

// File: tb/tb_rom_async.sv
// Scoreboard bench for rom_async: stimulus pushes expected words, a monitor
// pops and compares them against dout shortly after each stimulus step.
module tb_rom_async;

    typedef struct {
        string      name;
        logic [3:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    rom_async_if bus ();

    rom_async dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_t sb_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: output is combinational, so it is "presented" one time unit
    // after the stimulus that announced it.
    initial begin
        forever begin
            @(chk_ev);
            #1;
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (bus.dout !== e.exp) begin
                    errors++;
                    $display("FAIL %s: dout=%b expected=%b at %0t", e.name, bus.dout, e.exp,
                             $time);
                end
            end
        end
    end

    task automatic expect_dout(input string name, input logic [3:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        -> chk_ev;
        #2;
    endtask

    logic [5:0] live_addr [6] = '{6'd63, 6'd1, 6'd22, 6'd33, 6'd44, 6'd55};
    logic [3:0] live_exp  [6] = '{4'b1100, 4'b0001, 4'b0111, 4'b0011, 4'b1110, 4'b0100};
    logic [5:0] hold_addr [3] = '{6'd19, 6'd35, 6'd49};

    initial begin
        bus.en   = 1'b0;
        bus.addr = 6'd63;
        rst_n    = 1'b0;
        #2;
        expect_dout("reset_default", 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_dout("post_reset_idle", 4'b0000);
        end

        // Live reads land before the next rising edge.
        bus.en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.addr = live_addr[i];
            expect_dout("live_read", live_exp[i]);
        end

        // Exhaustive sweep against the defining formula.
        for (int a = 0; a < 64; a++) begin
            logic [5:0] av;
            av = 6'(a);
            bus.addr = av;
            expect_dout("sweep", av[3:0] ^ {2'b00, av[5:4]});
        end

        // Hold behaviour.
        @(negedge clk);
        bus.addr = 6'd44;
        @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0;
        expect_dout("hold_after_disable", 4'b1110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.addr = hold_addr[i];
            expect_dout("hold_addr_ignored", 4'b1110);
        end
        bus.en = 1'b1;
        expect_dout("reenable_live", 4'b0010);

        // Async reset between edges while holding.
        bus.addr = 6'd44;
        @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0;
        expect_dout("hold_before_reset", 4'b1110);
        rst_n = 1'b0;
        expect_dout("async_reset_clears", 4'b0000);
        bus.en   = 1'b1;
        bus.addr = 6'd63;
        expect_dout("live_during_reset", 4'b1100);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        expect_dout("no_load_in_reset", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_dout("release_stays_zero", 4'b0000);

        // Edge capture: addr/en change at the edge, hold uses pre-edge values.
        @(negedge clk);
        bus.en   = 1'b1;
        bus.addr = 6'd55;
        expect_dout("edge_pre_live", 4'b0100);
        @(posedge clk);
        bus.en   <= 1'b0;
        bus.addr <= 6'd12;
        #0;
        expect_dout("edge_capture", 4'b0100);
        @(negedge clk);
        bus.addr = 6'd0;
        expect_dout("edge_capture_held", 4'b0100);

        // Drain the scoreboard with a bound.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
